ccm_coe_bank: RTL and testbench

//  Coefficient bank feeding the 3x3 colour-matrix multiplier (Q4.10 signed coefficients).

---
 rtl/ccm_pkg.sv | 17 +
 rtl/vs_edge_det.sv | 17 +
 rtl/ccm_coe_bank.sv | 86 ++++++++
 tb/tb_ccm_coe_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// ccm_pkg: shared types and identity-set helper for the colour-matrix coefficient bank.
package ccm_pkg;
    localparam int CCM_COE_FRAC = 10;
    localparam int CCM_SET_MAX  = 1024;

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} ccm_coe_st_t;

    // Identity for a 3x3 matrix: 1.0 on the diagonal (row == col), zero elsewhere.
    function automatic logic [CCM_SET_MAX-1:0] ccm_identity(input int coe_width, input int coe_count,
                                                            input int frac = CCM_COE_FRAC);
        logic [CCM_SET_MAX-1:0] r;
        r = '0;
        for (int k = 0; k < coe_count; k++)
            if (k / 3 == k % 3) r[k*coe_width+frac] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/vs_edge_det.sv
// vs_edge_det: registers the frame-valid strobe and flags its rising and falling edges.
module vs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vs_i,
    output logic vs_rise,
    output logic vs_fall
);
    logic vs_d;

    always_ff @(posedge clk or posedge rst)
        if (rst) vs_d <= 1'b0;
        else     vs_d <= vs_i;

    assign vs_rise = ~vs_d & vs_i;
    assign vs_fall = vs_d & ~vs_i;
endmodule

// File: rtl/ccm_coe_bank.sv
// ccm_coe_bank: double-buffered Q4.10 coefficient set, committed only in the gap between frames.
// Optional readback port enabled by defining CCM_COE_RDBK_EN.
module ccm_coe_bank
    import ccm_pkg::*;
#(
    parameter int COE_WIDTH  = 16,
    parameter int COE_COUNT  = 9,
    parameter int COE_FRAC   = CCM_COE_FRAC,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [COE_WIDTH-1:0]           wr_data_i,
    input  logic                           commit_i,
    input  logic                           vs_i,
    output logic [COE_WIDTH*COE_COUNT-1:0] coe_o,
    output logic                           coe_upd_o,
    output logic                           busy_o,
    output logic                           err_o,
    input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
    output logic [COE_WIDTH-1:0]           rd_data_o
);
    localparam int SET_W = COE_WIDTH * COE_COUNT;
    localparam int IW    = $clog2(COE_COUNT);
    localparam logic [SET_W-1:0] IDENT = SET_W'(ccm_identity(COE_WIDTH, COE_COUNT, COE_FRAC));

    logic [COE_COUNT-1:0][COE_WIDTH-1:0] shadow, active;
    ccm_coe_st_t state;
    logic vs_fall, vs_rise_unused;
    logic wr_ok;

    vs_edge_det u_vs (
        .clk     (clk),
        .rst     (rst),
        .vs_i    (vs_i),
        .vs_rise (vs_rise_unused),
        .vs_fall (vs_fall)
    );

    assign wr_ok = state == IDLE && 32'(wr_addr_i) < COE_COUNT;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            shadow    <= IDENT;
            active    <= IDENT;
            coe_upd_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            coe_upd_o <= 1'b0;
            if (wr_en_i) begin
                if (wr_ok) shadow[wr_addr_i[IW-1:0]] <= wr_data_i;
                else       err_o <= 1'b1;
            end
            case (state)
                IDLE:    if (commit_i) state <= PENDING;
                PENDING: if (vs_fall)  state <= APPLY;
                APPLY: begin
                    active    <= shadow;
                    coe_upd_o <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

    assign busy_o = state != IDLE;
    assign coe_o  = active;

`ifdef CCM_COE_RDBK_EN
    // Addresses past the active set map onto the shadow set.
    logic [IW-1:0] rd_k;
    assign rd_k = IW'(rd_addr_i - ADDR_WIDTH'(COE_COUNT));

    always_ff @(posedge clk or posedge rst)
        if (rst) rd_data_o <= '0;
        else     rd_data_o <= 32'(rd_addr_i) < COE_COUNT     ? active[rd_addr_i[IW-1:0]] :
                              32'(rd_addr_i) < 2 * COE_COUNT ? shadow[rd_k] : '0;
`else
    logic rd_unused;
    assign rd_unused = ^rd_addr_i;
    assign rd_data_o = '0;
`endif
endmodule

// File: tb/tb_ccm_coe_bank.sv
// tb_ccm_coe_bank: directed stimulus, per-cycle model comparison plus literal spot checks.
module tb_ccm_coe_bank;
    localparam int W = 16, N = 9, AW = 4;

    logic clk = 1'b0, rst = 1'b0, wr_en_i = 1'b0, commit_i = 1'b0, vs_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
    logic [W-1:0] wr_data_i = '0;
    logic [W*N-1:0] coe_o;
    logic coe_upd_o, busy_o, err_o;
    logic [W-1:0] rd_data_o;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ccm_coe_bank dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .commit_i(commit_i), .vs_i(vs_i), .coe_o(coe_o), .coe_upd_o(coe_upd_o), .busy_o(busy_o),
        .err_o(err_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
    );

    // Reference model: shadow/active arrays, a pending flag and a one-cycle apply flag.
    logic [W-1:0] m_sh[N], m_ac[N], m_rd;
    logic m_pend, m_apply, m_upd, m_err, m_vsd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_sh[k] <= (k % 4 == 0) ? 16'h0400 : 16'h0000;
                m_ac[k] <= (k % 4 == 0) ? 16'h0400 : 16'h0000;
            end
            {m_pend, m_apply, m_upd, m_err, m_vsd} <= '0;
            m_rd <= '0;
        end else begin
            m_vsd <= vs_i;
            m_upd <= 1'b0;
            if (m_apply) begin
                for (int k = 0; k < N; k++) m_ac[k] <= m_sh[k];
                m_upd <= 1'b1;
                m_apply <= 1'b0;
            end else if (m_pend && m_vsd && !vs_i) begin
                m_pend <= 1'b0;
                m_apply <= 1'b1;
            end else if (!m_pend && commit_i) m_pend <= 1'b1;
            if (wr_en_i) begin
                if (m_pend || m_apply || int'(wr_addr_i) >= N) m_err <= 1'b1;
                else m_sh[wr_addr_i] <= wr_data_i;
            end
`ifdef CCM_COE_RDBK_EN
            m_rd <= int'(rd_addr_i) < N ? m_ac[rd_addr_i] :
                    int'(rd_addr_i) < 2 * N ? m_sh[int'(rd_addr_i) - N] : 16'h0000;
`endif
        end
    end

    logic [W*N-1:0] m_vec;
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) m_vec[k*W+:W] = m_ac[k];
        total++;
        if (coe_o !== m_vec || coe_upd_o !== m_upd || busy_o !== (m_pend || m_apply) ||
            err_o !== m_err || rd_data_o !== m_rd) begin
            bad++;
            $display("FAIL model t=%0t coe=%h want %h upd=%b/%b busy=%b/%b err=%b/%b rd=%h/%h",
                     $time, coe_o, m_vec, coe_upd_o, m_upd, busy_o, m_pend || m_apply,
                     err_o, m_err, rd_data_o, m_rd);
        end
    end

    function automatic logic [W-1:0] c(input int k);
        return coe_o[k*W+:W];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick(1);
        wr_en_i = 1'b0;
    endtask

    // Cycles from the vs_i drop until coe_upd_o; 2 is the expected latency.
    task automatic wait_upd(input string name);
        int i = 0;
        while (!coe_upd_o && i < 20) begin
            tick(1);
            i++;
        end
        chk({name, "_latency"}, 16'(i), 16'd2);
    endtask

    int saw_upd;
    initial begin
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_c0", c(0), 16'h0400);
        chk("rst_c1", c(1), 16'h0000);
        chk("rst_c4", c(4), 16'h0400);
        chk("rst_c5", c(5), 16'h0000);
        chk("rst_c8", c(8), 16'h0400);
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_err", 16'(err_o), 16'd0);
        chk("rst_upd", 16'(coe_upd_o), 16'd0);

        // write and commit in the same cycle, then a write while pending
        vs_i = 1'b1;
        tick(2);
        wr_en_i = 1'b1; wr_addr_i = 4'd1; wr_data_i = 16'hFC00; commit_i = 1'b1;
        tick(1);
        wr_en_i = 1'b0; commit_i = 1'b0;
        tick(1);
        chk("pend_busy", 16'(busy_o), 16'd1);
        chk("pend_c1", c(1), 16'h0000);
        wr(4'd2, 16'h0200);
        tick(1);
        chk("pend_wr_err", 16'(err_o), 16'd1);
        tick(3);
        chk("midframe_c1", c(1), 16'h0000);
        vs_i = 1'b0;
        wait_upd("apply1");
        chk("apply1_c1", c(1), 16'hFC00);
        chk("apply1_c2", c(2), 16'h0000);
        chk("apply1_busy", 16'(busy_o), 16'd0);
        tick(1);
        chk("apply1_upd_off", 16'(coe_upd_o), 16'd0);

        // reset while a commit is pending
        vs_i = 1'b1; commit_i = 1'b1;
        tick(1);
        commit_i = 1'b0;
        tick(2);
        chk("pre_rst_busy", 16'(busy_o), 16'd1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0; vs_i = 1'b0;
        saw_upd = 0;
        repeat (5) begin
            tick(1);
            if (coe_upd_o) saw_upd++;
        end
        chk("rst_mid_upd", 16'(saw_upd), 16'd0);
        chk("rst_mid_busy", 16'(busy_o), 16'd0);
        chk("rst_mid_c1", c(1), 16'h0000);
        chk("rst_mid_err", 16'(err_o), 16'd0);

        // out-of-range write is dropped and flagged
        wr(4'd9, 16'h1234);
        chk("bad_addr_err", 16'(err_o), 16'd1);
        vs_i = 1'b1; commit_i = 1'b1;
        tick(1);
        commit_i = 1'b0;
        tick(2);
        vs_i = 1'b0;
        wait_upd("apply2");
        chk("apply2_c0", c(0), 16'h0400);
        chk("apply2_c1", c(1), 16'h0000);
        chk("apply2_c8", c(8), 16'h0400);

        // commit on the same cycle as a vs fall waits for the next frame
        wr(4'd3, 16'h0155);
        vs_i = 1'b1;
        tick(3);
        vs_i = 1'b0; commit_i = 1'b1;
        tick(1);
        commit_i = 1'b0;
        tick(4);
        chk("coinc_busy", 16'(busy_o), 16'd1);
        chk("coinc_c3", c(3), 16'h0000);
        vs_i = 1'b1;
        tick(2);
        vs_i = 1'b0;
        wait_upd("apply3");
        chk("apply3_c3", c(3), 16'h0155);

`ifdef CCM_COE_RDBK_EN
        wr(4'd4, 16'h0800);
        rd_addr_i = 4'd13;
        tick(1);
        chk("rd_shadow4", rd_data_o, 16'h0800);
        rd_addr_i = 4'd4;
        tick(1);
        chk("rd_active4_pre", rd_data_o, 16'h0400);
        vs_i = 1'b1; commit_i = 1'b1;
        tick(1);
        commit_i = 1'b0;
        tick(1);
        vs_i = 1'b0;
        wait_upd("apply4");
        tick(1);
        chk("rd_active4_post", rd_data_o, 16'h0800);
`else
        rd_addr_i = 4'd4;
        tick(2);
        chk("rd_tied0", rd_data_o, 16'h0000);
`endif
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
